// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 16-bit ALU between two requesters.
// Port 0 is the execute-stage issue path and port 1 is the address/branch helper.
// The winner's operands are registered toward the ALU. After LAT settle cycles the
// ALU outputs are captured into the result registers, and the granted port receives
// a one-cycle done pulse.
module alu_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int LAT        = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [4:0]  op0,
  input  logic        sign0,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic        req1,
  input  logic [4:0]  op1,
  input  logic        sign1,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] result,
  output logic        ofl,
  output logic        zero,
  output logic        busy,
  output logic [15:0] alu_A,
  output logic [15:0] alu_B,
  output logic [4:0]  alu_Op,
  output logic        alu_sign,
  input  logic [15:0] alu_Out,
  input  logic        alu_OFL,
  input  logic        alu_Zero
);

  typedef enum logic {IDLE, EXEC} state_t;

  // Only 1..4 settle cycles fit the 2-bit countdown; anything else stops elaboration.
  if (LAT < 1 || LAT > 4) begin : gLatCheck
    $error("alu_arbiter: LAT must be in the range 1..4");
  end

  localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic        lastGnt_q;
  logic        gnt0_q;
  logic        gnt1_q;
  logic        done0_q;
  logic        done1_q;
  logic [15:0] result_q;
  logic        ofl_q;
  logic        zero_q;
  logic [15:0] aluA_q;
  logic [15:0] aluB_q;
  logic [4:0]  aluOp_q;
  logic        aluSign_q;

  logic        anyReq;
  logic        winner_d;

  // Choose which port would win if arbitration happens this cycle (1 = port 1).
  always_comb begin
    anyReq   = req0 | req1;
    winner_d = 1'b0;
    if (req0 && req1) begin
      winner_d = (FIXED_PRIO != 0) ? 1'b0 : ~lastGnt_q;
    end else if (req1) begin
      winner_d = 1'b1;
    end
  end

  // Arbitration/settle FSM; every output pulse and ALU operand is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      lastGnt_q <= 1'b1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      result_q  <= 16'd0;
      ofl_q     <= 1'b0;
      zero_q    <= 1'b0;
      aluA_q    <= 16'd0;
      aluB_q    <= 16'd0;
      aluOp_q   <= 5'd0;
      aluSign_q <= 1'b0;
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (anyReq) begin
            aluOp_q   <= winner_d ? op1   : op0;
            aluSign_q <= winner_d ? sign1 : sign0;
            aluA_q    <= winner_d ? a1    : a0;
            aluB_q    <= winner_d ? b1    : b0;
            lastGnt_q <= winner_d;
            cnt_q     <= CNT_INIT;
            gnt0_q    <= ~winner_d;
            gnt1_q    <= winner_d;
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q == 2'd0) begin
            result_q <= alu_Out;
            ofl_q    <= alu_OFL;
            zero_q   <= alu_Zero;
            done0_q  <= ~lastGnt_q;
            done1_q  <= lastGnt_q;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign result   = result_q;
  assign ofl      = ofl_q;
  assign zero     = zero_q;
  assign busy     = (state_q == EXEC);
  assign alu_A    = aluA_q;
  assign alu_B    = aluB_q;
  assign alu_Op   = aluOp_q;
  assign alu_sign = aluSign_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: three arbiter instances, each driving its own stand-in ALU.
// Instance 0 uses round-robin with LAT=1, instance 1 uses fixed priority with LAT=1,
// and instance 2 uses round-robin with LAT=3.
// Expected results are queued per instance/port when a request is driven and are
// popped when the matching done pulse appears.
module tb_alu_arbiter;

  localparam int N = 3;
  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_UND = 5'd31;

  typedef logic [17:0] exp_t;   // {result, ofl, zero}

  logic clk;
  logic rst;
  logic [N-1:0]       req0, sign0, req1, sign1;
  logic [N-1:0][4:0]  op0, op1;
  logic [N-1:0][15:0] a0, b0, a1, b1;
  logic [N-1:0]       gnt0, gnt1, done0, done1, ofl, zero, busy;
  logic [N-1:0]       aluSign, aluOfl, aluZero;
  logic [N-1:0][15:0] result, aluA, aluB, aluOut;
  logic [N-1:0][4:0]  aluOp;

  exp_t expQ[2*N][$];
  int   total = 0;
  int   bad   = 0;

  // Stand-in ALU: ADD/SUB/AND/OR; any other opcode returns 0xBADA.
  function automatic exp_t aluRef(input logic [4:0] op, input logic s,
                                  input logic [15:0] a, input logic [15:0] b);
    logic [16:0] w;
    logic [15:0] r;
    logic        o;
    w = 17'd0;
    o = 1'b0;
    case (op)
      OP_ADD: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[15:0];
        o = s ? ((a[15] == b[15]) && (r[15] != a[15])) : w[16];
      end
      OP_SUB: begin
        w = {1'b0, a} - {1'b0, b};
        r = w[15:0];
        o = s ? ((a[15] != b[15]) && (r[15] != a[15])) : w[16];
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      default: r = 16'hBADA;
    endcase
    return {r, o, (r == 16'd0)};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] outVec(input int i);
    return 64'({gnt0[i], gnt1[i], done0[i], done1[i], result[i], ofl[i], zero[i], busy[i],
                aluA[i], aluB[i], aluOp[i], aluSign[i]});
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : gDut
    alu_arbiter #(.FIXED_PRIO(g == 1 ? 1 : 0), .LAT(g == 2 ? 3 : 1)) uDut (
      .clk(clk), .rst(rst),
      .req0(req0[g]), .op0(op0[g]), .sign0(sign0[g]), .a0(a0[g]), .b0(b0[g]),
      .req1(req1[g]), .op1(op1[g]), .sign1(sign1[g]), .a1(a1[g]), .b1(b1[g]),
      .gnt0(gnt0[g]), .gnt1(gnt1[g]), .done0(done0[g]), .done1(done1[g]),
      .result(result[g]), .ofl(ofl[g]), .zero(zero[g]), .busy(busy[g]),
      .alu_A(aluA[g]), .alu_B(aluB[g]), .alu_Op(aluOp[g]), .alu_sign(aluSign[g]),
      .alu_Out(aluOut[g]), .alu_OFL(aluOfl[g]), .alu_Zero(aluZero[g])
    );

    assign {aluOut[g], aluOfl[g], aluZero[g]} = aluRef(aluOp[g], aluSign[g], aluA[g], aluB[g]);

    // Scoreboard: match done pulses against queued expectations and check exclusivity.
    always @(negedge clk) begin
      exp_t e;
      if (expQ[2*g].size() == 0) begin
        checkOutput("spurDone0", 64'(done0[g]), 64'd0);
      end else if (done0[g]) begin
        e = expQ[2*g].pop_front();
        checkOutput("res0", 64'({result[g], ofl[g], zero[g]}), 64'(e));
      end
      if (expQ[2*g+1].size() == 0) begin
        checkOutput("spurDone1", 64'(done1[g]), 64'd0);
      end else if (done1[g]) begin
        e = expQ[2*g+1].pop_front();
        checkOutput("res1", 64'({result[g], ofl[g], zero[g]}), 64'(e));
      end
      if (gnt0[g] | gnt1[g] | done0[g] | done1[g]) begin
        checkOutput("exclusive", 64'({gnt0[g] & gnt1[g], done0[g] & done1[g],
                                      gnt0[g] & done0[g], gnt1[g] & done1[g]}), 64'd0);
      end
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int i, input int p, input logic [4:0] op, input logic s,
                               input logic [15:0] a, input logic [15:0] b);
    if (p == 0) begin
      req0[i] = 1'b1; op0[i] = op; sign0[i] = s; a0[i] = a; b0[i] = b;
    end else begin
      req1[i] = 1'b1; op1[i] = op; sign1[i] = s; a1[i] = a; b1[i] = b;
    end
  endtask

  task automatic dropReq(input int i, input int p);
    if (p == 0) req0[i] = 1'b0;
    else        req1[i] = 1'b0;
  endtask

  task automatic pushExp(input int i, input int p, input exp_t e);
    expQ[2*i+p].push_back(e);
  endtask

  task automatic resetDut;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
  endtask

  // Bounded wait for port p's done, releasing its request once the grant shows.
  task automatic waitDone(input int i, input int p);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick;
      if ((p == 0) ? gnt0[i] : gnt1[i]) dropReq(i, p);
      if ((p == 0) ? done0[i] : done1[i]) found = 1'b1;
    end
    checkOutput("waitDone", 64'(found), 64'd1);
  endtask

  task automatic runOp(input int i, input int p, input logic [4:0] op, input logic s,
                       input logic [15:0] a, input logic [15:0] b);
    applyStimulus(i, p, op, s, a, b);
    pushExp(i, p, aluRef(op, s, a, b));
    waitDone(i, p);
  endtask

  initial begin
    logic [4:0] opsTab[5];
    opsTab = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_UND};
    rst = 1'b0;
    req0 = '0; sign0 = '0; req1 = '0; sign1 = '0;
    op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;

    // Reset values on every instance
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) checkOutput("rstOut", outVec(i), 64'd0);
    tick;
    rst = 1'b0;
    tick;

    // Single request, LAT=1
    applyStimulus(0, 0, OP_ADD, 1'b0, 16'h0003, 16'h0004);
    pushExp(0, 0, {16'h0007, 1'b0, 1'b0});
    tick;
    checkOutput("t1Gnt0", 64'(gnt0[0]), 64'd1);
    checkOutput("t1Gnt1", 64'(gnt1[0]), 64'd0);
    checkOutput("t1Busy", 64'(busy[0]), 64'd1);
    checkOutput("t1Done0", 64'(done0[0]), 64'd0);
    dropReq(0, 0);
    tick;
    checkOutput("t1Done0b", 64'(done0[0]), 64'd1);
    checkOutput("t1Done1", 64'(done1[0]), 64'd0);
    checkOutput("t1BusyB", 64'(busy[0]), 64'd0);
    checkOutput("t1Res", 64'(result[0]), 64'h0007);
    tick;
    checkOutput("t1DoneOff", 64'(done0[0]), 64'd0);
    checkOutput("t1Hold", 64'(result[0]), 64'h0007);

    // Round-robin contention
    resetDut;
    applyStimulus(0, 0, OP_AND, 1'b0, 16'h00FF, 16'h0F0F);
    applyStimulus(0, 1, OP_OR,  1'b0, 16'h00F0, 16'h000F);
    pushExp(0, 0, {16'h000F, 1'b0, 1'b0});
    pushExp(0, 1, {16'h00FF, 1'b0, 1'b0});
    tick;
    checkOutput("t2Gnt0", 64'({gnt0[0], gnt1[0]}), 64'b10);
    dropReq(0, 0);
    tick;
    checkOutput("t2Done0", 64'({done0[0], gnt1[0]}), 64'b10);
    tick;
    checkOutput("t2Gnt1", 64'({gnt0[0], gnt1[0]}), 64'b01);
    dropReq(0, 1);
    tick;
    checkOutput("t2Done1", 64'(done1[0]), 64'd1);
    checkOutput("t2Res", 64'(result[0]), 64'h00FF);
    applyStimulus(0, 0, OP_ADD, 1'b0, 16'h0001, 16'h0001);
    applyStimulus(0, 1, OP_ADD, 1'b0, 16'h0002, 16'h0002);
    pushExp(0, 0, {16'h0002, 1'b0, 1'b0});
    pushExp(0, 1, {16'h0004, 1'b0, 1'b0});
    tick;
    checkOutput("t2Back0", 64'({gnt0[0], gnt1[0]}), 64'b10);
    dropReq(0, 0);
    waitDone(0, 1);

    // Fixed priority: port 0 starves port 1 while it keeps requesting
    resetDut;
    applyStimulus(1, 0, OP_ADD, 1'b0, 16'h0001, 16'h0002);
    applyStimulus(1, 1, OP_ADD, 1'b0, 16'h0005, 16'h0005);
    for (int k = 0; k < 4; k++) pushExp(1, 0, {16'h0003, 1'b0, 1'b0});
    pushExp(1, 1, {16'h000A, 1'b0, 1'b0});
    for (int c = 1; c <= 8; c++) begin
      tick;
      checkOutput("t3Gnt0", 64'(gnt0[1]), 64'(c % 2));
      checkOutput("t3Gnt1", 64'(gnt1[1]), 64'd0);
      if (c == 7) dropReq(1, 0);
    end
    tick;
    checkOutput("t3Gnt1Late", 64'(gnt1[1]), 64'd1);
    dropReq(1, 1);
    tick;
    checkOutput("t3Done1", 64'(done1[1]), 64'd1);

    // Signed versus unsigned overflow on port 1
    resetDut;
    applyStimulus(0, 1, OP_ADD, 1'b1, 16'h7FFF, 16'h0001);
    pushExp(0, 1, {16'h8000, 1'b1, 1'b0});
    waitDone(0, 1);
    checkOutput("t4OflS", 64'(ofl[0]), 64'd1);
    applyStimulus(0, 1, OP_ADD, 1'b0, 16'h7FFF, 16'h0001);
    pushExp(0, 1, {16'h8000, 1'b0, 1'b0});
    waitDone(0, 1);
    checkOutput("t4OflU", 64'(ofl[0]), 64'd0);

    // LAT=3 timing and operand capture at grant
    resetDut;
    applyStimulus(2, 0, OP_ADD, 1'b0, 16'h0010, 16'h0001);
    pushExp(2, 0, {16'h0011, 1'b0, 1'b0});
    tick;
    checkOutput("t5Gnt0", 64'({gnt0[2], busy[2]}), 64'b11);
    dropReq(2, 0);
    a0[2] = 16'h1234;
    tick;
    checkOutput("t5C2", 64'({gnt0[2], busy[2], done0[2]}), 64'b010);
    checkOutput("t5AluA", 64'(aluA[2]), 64'h0010);
    tick;
    checkOutput("t5C3", 64'({busy[2], done0[2]}), 64'b10);
    tick;
    checkOutput("t5C4", 64'({busy[2], done0[2]}), 64'b01);
    checkOutput("t5Res", 64'(result[2]), 64'h0011);

    // Reset in the middle of a LAT=3 operation
    applyStimulus(2, 0, OP_SUB, 1'b0, 16'h0009, 16'h0002);
    tick;
    checkOutput("t6Gnt0", 64'(gnt0[2]), 64'd1);
    dropReq(2, 0);
    tick;
    checkOutput("t6Busy", 64'(busy[2]), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("t6RstOut", outVec(2), 64'd0);
    tick;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick;
      checkOutput("t6NoDone", 64'({done0[2], done1[2]}), 64'd0);
    end
    applyStimulus(2, 0, OP_SUB, 1'b0, 16'h0005, 16'h0005);
    applyStimulus(2, 1, OP_OR,  1'b0, 16'hA000, 16'h0005);
    pushExp(2, 0, {16'h0000, 1'b0, 1'b1});
    pushExp(2, 1, {16'hA005, 1'b0, 1'b0});
    tick;
    checkOutput("t6First", 64'({gnt0[2], gnt1[2]}), 64'b10);
    dropReq(2, 0);
    waitDone(2, 1);

    // Undefined opcode passes through, then a mixed sequence on both ports
    resetDut;
    applyStimulus(0, 0, OP_UND, 1'b0, 16'h1111, 16'h2222);
    pushExp(0, 0, {16'hBADA, 1'b0, 1'b0});
    waitDone(0, 0);
    checkOutput("t7Und", 64'(result[0]), 64'hBADA);
    for (int k = 0; k < 8; k++) begin
      runOp(0, k % 2, opsTab[$urandom_range(0, 4)], 1'($urandom_range(0, 1)),
            16'($urandom), 16'($urandom));
    end

    tick;
    tick;
    for (int q = 0; q < 2*N; q++) checkOutput("sbDrain", 64'(expQ[q].size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 16-bit ALU instance between two requesters: port 0 is the execute-stage issue path, port 1 is the address/branch helper path.
- Arbitrates between them, latches the winner's operands into registers that drive the ALU, and waits a configurable settle time.
- Captures Out/OFL/Zero into a result register and returns it with a one-cycle done pulse to the granted requester.
- Sits between the requesters and the ALU; the ALU itself stays purely combinational.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between ports; 1 = port 0 always wins on contention.
- LAT, 1: ALU settle cycles before capture; legal range 1..4. Other values are a compile-time error (generate-time check).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req0  in  1  port 0 request; level, sampled only in IDLE
- op0  in  5  port 0 ALU opcode, ALU encoding (ADD=0 ... HALT=29)
- sign0  in  1  port 0 signed/unsigned select
- a0, b0  in  16 each  port 0 operands A, B
- req1, op1, sign1, a1, b1  in  1/5/1/16/16  port 1 equivalents
- gnt0, gnt1  out  1 each  one-cycle grant pulse
- done0, done1  out  1 each  one-cycle result-valid pulse
- result  out  16  captured ALU Out
- ofl  out  1  captured ALU OFL
- zero  out  1  captured ALU Zero
- busy  out  1  high when state is EXEC
- alu_A, alu_B  out  16 each  registered operands to ALU
- alu_Op  out  5  registered opcode to ALU
- alu_sign  out  1  registered sign to ALU
- alu_Out  in  16  ALU result
- alu_OFL, alu_Zero  in  1 each  ALU flags

Behaviour:
- Reset values:
  - All outputs 0; alu_A/alu_B/alu_Op/alu_sign = 0.
  - state = IDLE; settle counter = 0.
  - last_gnt = 1, so port 0 wins the first contention.
- FSM states: IDLE, EXEC.
- IDLE:
  - If any req is high at a clock edge, choose a winner:
    - Only one port requesting: that port wins.
    - Both requesting, FIXED_PRIO=1: port 0 wins.
    - Both requesting, FIXED_PRIO=0: the port != last_gnt wins.
  - On that edge:
    - Latch the winner's op/sign/a/b into the alu_* registers.
    - Set last_gnt to the winner.
    - Load counter = LAT-1.
    - Assert the winner's gnt for the next cycle only.
    - Go to EXEC.
  - No req high: remain in IDLE; alu_* registers hold their values.
- EXEC:
  - busy=1; req inputs are ignored.
  - Counter decrements each edge.
  - At the edge where counter == 0:
    - Capture alu_Out/alu_OFL/alu_Zero into result/ofl/zero.
    - Pulse done of the granted port for the next cycle.
    - Return to IDLE.
- Latency: request sampled at edge E -> gnt in cycle E+1 -> done and result valid in cycle E+LAT+1.
  - Back-to-back operations: one every LAT+1 cycles. The IDLE cycle that carries done also arbitrates.
- Requester contract:
  - Hold req and operands stable until gnt is seen.
  - Deassert req in the gnt cycle or the next cycle.
  - A req still high in IDLE is treated as a new operation; this is legal for streaming.
- Operands are captured at grant; later changes on a*/b* have no effect on the operation in flight.
- result/ofl/zero hold the last captured value until the next capture. Zero is not cleared on done deassert.
- gnt and done are never high for both ports in the same cycle. gntX and doneX are never high in the same cycle.
- Reset mid-EXEC: operation is abandoned; no done is issued; all registers return to reset values.
- Undefined opcodes are passed unchanged to the ALU, which returns 0xBADA. The arbiter performs no opcode checking.

Test Plan:
- Single request, LAT=1: req0 with ADD, a0=0x0003, b0=0x0004, sampled at edge 1 -> gnt0 in cycle 1 only, busy in cycle 1, done0 in cycle 2, result=0x0007, ofl=0, done1/gnt1 stay 0.
- Contention, round-robin, LAT=1: req0 and req1 both held high after reset; port 0 issues AND 0x00FF,0x0F0F and port 1 issues OR 0x00F0,0x000F -> gnt0 cycle 1, done0 cycle 2 with 0x000F; gnt1 cycle 3, done1 cycle 4 with 0x00FF; the next grant goes back to port 0.
- FIXED_PRIO=1: both ports request continuously -> port 0 is granted every 2 cycles; gnt1 never asserts while req0 stays high.
- Signed overflow: port 1 ADD, sign1=1, a1=0x7FFF, b1=0x0001 -> result=0x8000, ofl=1 on done1. Then the same operation with sign1=0 -> ofl=0.
- LAT=3 timing plus operand stability: request at edge 1 and a0 changed during EXEC -> gnt0 cycle 1, busy cycles 1-3, done0 cycle 4, result uses the original a0.
- Reset mid-op: assert rst during cycle 2 of a LAT=3 EXEC -> all outputs 0 immediately; no done pulses; after release the first contention grants port 0.
